// File: rtl/hazard_ctrl.sv
// hazard_ctrl: D-stage hazard detection and operand forwarding for the
// 5-stage core. Tracks in-flight writers in E/M/W shadow slots, raises the
// D-stage stall (with bubble injection into E) and selects forwarding
// sources for D, E and M operands.
// Optional: define HAZARD_STALL_CNT_EN to add a saturating stall_cnt output.
module hazard_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  d_rd_addr0,
   input  logic [4:0]  d_rd_addr1,
   input  logic [1:0]  d_rd_stage0,
   input  logic [1:0]  d_rd_stage1,
   input  logic [4:0]  d_wr_addr,
   input  logic [1:0]  d_wr_stage,
   output logic        stall,
   output logic [1:0]  fwd_d0,
   output logic [1:0]  fwd_d1,
   output logic [1:0]  fwd_e0,
   output logic [1:0]  fwd_e1,
   output logic [1:0]  fwd_m1,
   output logic [4:0]  e_wr_addr,
   output logic [4:0]  m_wr_addr,
   output logic [4:0]  w_wr_addr
`ifdef HAZARD_STALL_CNT_EN
   ,
   output logic [31:0] stall_cnt
`endif
);

   // Slot positions in the pipeline (E=1, M=2, W=3).
   localparam logic [2:0] POS_E = 3'd1;
   localparam logic [2:0] POS_M = 3'd2;

   // Forwarding source encodings.
   localparam logic [1:0] SRC_NONE = 2'd0;
   localparam logic [1:0] SRC_E    = 2'd1;
   localparam logic [1:0] SRC_M    = 2'd2;
   localparam logic [1:0] SRC_W    = 2'd3;

   // E slot
   logic [4:0] e_wr_addr_q,  e_wr_addr_d;
   logic [1:0] e_wr_stage_q, e_wr_stage_d;
   logic [4:0] e_rd_addr0_q, e_rd_addr0_d;
   logic [4:0] e_rd_addr1_q, e_rd_addr1_d;
   logic [1:0] e_rd_stage0_q, e_rd_stage0_d;
   logic [1:0] e_rd_stage1_q, e_rd_stage1_d;
   // M slot
   logic [4:0] m_wr_addr_q;
   logic [1:0] m_wr_stage_q;
   logic [4:0] m_rd_addr1_q;
   logic [1:0] m_rd_stage1_q;
   // W slot
   logic [4:0] w_wr_addr_q;

   logic       term0, term1;

   // Register 0 is hard-wired, so it never takes part in a hazard.
   function automatic logic match(input logic [4:0] slot_addr, input logic [4:0] a);
      return (a != 5'd0) && (slot_addr == a);
   endfunction

   // Only the newest matching slot decides: an older writer of the same
   // register is shadowed by the newer one.
   function automatic logic stall_term(input logic [4:0] a, input logic [1:0] use_stage,
                                       input logic [4:0] e_addr, input logic [1:0] e_stage,
                                       input logic [4:0] m_addr, input logic [1:0] m_stage);
      if (match(e_addr, a))
         return {1'b0, e_stage} >= (POS_E + {1'b0, use_stage});
      else if (match(m_addr, a))
         return {1'b0, m_stage} >= (POS_M + {1'b0, use_stage});
      return 1'b0;
   endfunction

   function automatic logic [1:0] src_d(input logic [4:0] a, input logic [4:0] e_addr,
                                        input logic [4:0] m_addr, input logic [4:0] w_addr);
      if (match(e_addr, a))      return SRC_E;
      else if (match(m_addr, a)) return SRC_M;
      else if (match(w_addr, a)) return SRC_W;
      return SRC_NONE;
   endfunction

   // M forwards to E only once its result exists (wr_stage below M).
   function automatic logic [1:0] src_e(input logic [4:0] a, input logic [4:0] m_addr,
                                        input logic [1:0] m_stage, input logic [4:0] w_addr);
      if (match(m_addr, a) && ({1'b0, m_stage} < POS_M)) return SRC_M;
      else if (match(w_addr, a))                        return SRC_W;
      return SRC_NONE;
   endfunction

   // Hazard detection and forwarding selects from slot state and D inputs.
   always_comb begin
      term0  = stall_term(d_rd_addr0, d_rd_stage0, e_wr_addr_q, e_wr_stage_q,
                          m_wr_addr_q, m_wr_stage_q);
      term1  = stall_term(d_rd_addr1, d_rd_stage1, e_wr_addr_q, e_wr_stage_q,
                          m_wr_addr_q, m_wr_stage_q);
      stall  = term0 | term1;
      fwd_d0 = src_d(d_rd_addr0, e_wr_addr_q, m_wr_addr_q, w_wr_addr_q);
      fwd_d1 = src_d(d_rd_addr1, e_wr_addr_q, m_wr_addr_q, w_wr_addr_q);
      fwd_e0 = src_e(e_rd_addr0_q, m_wr_addr_q, m_wr_stage_q, w_wr_addr_q);
      fwd_e1 = src_e(e_rd_addr1_q, m_wr_addr_q, m_wr_stage_q, w_wr_addr_q);
      fwd_m1 = match(w_wr_addr_q, m_rd_addr1_q) ? SRC_W : SRC_NONE;
   end

   // E slot next state: a stalled D instruction leaves a bubble behind it.
   always_comb begin
      e_wr_addr_d   = '0;
      e_wr_stage_d  = '0;
      e_rd_addr0_d  = '0;
      e_rd_addr1_d  = '0;
      e_rd_stage0_d = '0;
      e_rd_stage1_d = '0;
      if (!stall) begin
         e_wr_addr_d   = d_wr_addr;
         e_wr_stage_d  = d_wr_stage;
         e_rd_addr0_d  = d_rd_addr0;
         e_rd_addr1_d  = d_rd_addr1;
         e_rd_stage0_d = d_rd_stage0;
         e_rd_stage1_d = d_rd_stage1;
      end
   end

   // Slot pipeline: E <= D (or bubble), M <= E, W <= M.
   always_ff @(posedge clk) begin
      if (reset) begin
         e_wr_addr_q   <= '0;
         e_wr_stage_q  <= '0;
         e_rd_addr0_q  <= '0;
         e_rd_addr1_q  <= '0;
         e_rd_stage0_q <= '0;
         e_rd_stage1_q <= '0;
         m_wr_addr_q   <= '0;
         m_wr_stage_q  <= '0;
         m_rd_addr1_q  <= '0;
         m_rd_stage1_q <= '0;
         w_wr_addr_q   <= '0;
      end else begin
         e_wr_addr_q   <= e_wr_addr_d;
         e_wr_stage_q  <= e_wr_stage_d;
         e_rd_addr0_q  <= e_rd_addr0_d;
         e_rd_addr1_q  <= e_rd_addr1_d;
         e_rd_stage0_q <= e_rd_stage0_d;
         e_rd_stage1_q <= e_rd_stage1_d;
         m_wr_addr_q   <= e_wr_addr_q;
         m_wr_stage_q  <= e_wr_stage_q;
         m_rd_addr1_q  <= e_rd_addr1_q;
         m_rd_stage1_q <= e_rd_stage1_q;
         w_wr_addr_q   <= m_wr_addr_q;
      end
   end

   // Use-stage fields are tracked with their slot for completeness, but
   // these two have no consumer in the current forwarding network.
   logic unused_stage_bits;
   assign unused_stage_bits = ^{e_rd_stage0_q, m_rd_stage1_q};

   assign e_wr_addr = e_wr_addr_q;
   assign m_wr_addr = m_wr_addr_q;
   assign w_wr_addr = w_wr_addr_q;

`ifdef HAZARD_STALL_CNT_EN
   logic [31:0] stall_cnt_q;

   // Saturating count of stalled cycles.
   always_ff @(posedge clk) begin
      if (reset)
         stall_cnt_q <= '0;
      else if (stall && (stall_cnt_q != '1))
         stall_cnt_q <= stall_cnt_q + 32'd1;
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; optional stall counter checked when
// HAZARD_STALL_CNT_EN is defined.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] d_rd_addr0, d_rd_addr1, d_wr_addr;
   logic [1:0] d_rd_stage0, d_rd_stage1, d_wr_stage;
   logic       stall;
   logic [1:0] fwd_d0, fwd_d1, fwd_e0, fwd_e1, fwd_m1;
   logic [4:0] e_wr_addr, m_wr_addr, w_wr_addr;
`ifdef HAZARD_STALL_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] cnt_snap;
`endif

   int unsigned total = 0;
   int unsigned bad   = 0;

   hazard_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .d_rd_addr0  (d_rd_addr0),
      .d_rd_addr1  (d_rd_addr1),
      .d_rd_stage0 (d_rd_stage0),
      .d_rd_stage1 (d_rd_stage1),
      .d_wr_addr   (d_wr_addr),
      .d_wr_stage  (d_wr_stage),
      .stall       (stall),
      .fwd_d0      (fwd_d0),
      .fwd_d1      (fwd_d1),
      .fwd_e0      (fwd_e0),
      .fwd_e1      (fwd_e1),
      .fwd_m1      (fwd_m1),
      .e_wr_addr   (e_wr_addr),
      .m_wr_addr   (m_wr_addr),
      .w_wr_addr   (w_wr_addr)
`ifdef HAZARD_STALL_CNT_EN
      ,
      .stall_cnt   (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Drive a D-stage descriptor, then let combinational outputs settle.
   task automatic set_d(input logic [4:0] ra0, input logic [1:0] rs0,
                        input logic [4:0] ra1, input logic [1:0] rs1,
                        input logic [4:0] wa,  input logic [1:0] ws);
      d_rd_addr0  = ra0;
      d_rd_stage0 = rs0;
      d_rd_addr1  = ra1;
      d_rd_stage1 = rs1;
      d_wr_addr   = wa;
      d_wr_stage  = ws;
      #1;
   endtask

   task automatic nop();
      set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0);
   endtask

   // Advance one rising edge; inputs are changed #1 after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".stall"}, 32'(stall), 32'd0);
      chk({tag, ".fwd"}, 32'({fwd_d0, fwd_d1, fwd_e0, fwd_e1, fwd_m1}), 32'd0);
      chk({tag, ".slots"}, 32'({e_wr_addr, m_wr_addr, w_wr_addr}), 32'd0);
   endtask

   task automatic flush();
      nop();
      repeat (3) tick();
   endtask

   initial begin
      // 1: reset with D inputs addr 5 / stage 0
      reset = 1'b1;
      set_d(5'd5, 2'd0, 5'd5, 2'd0, 5'd5, 2'd0);
      tick();
      chk_all_zero("rst1");
      tick();
      chk_all_zero("rst2");
      reset = 1'b0;
      nop();
      tick();
      chk_all_zero("post_rst");

      // 2: addu $3 (wr_stage 1) then beq $3,$0
      set_d(5'd1, 2'd1, 5'd2, 2'd1, 5'd3, 2'd1);
      chk("addu.stall", 32'(stall), 32'd0);
      tick();
      set_d(5'd3, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
      chk("beq.stall1", 32'(stall), 32'd1);
      tick();
      chk("beq.stall2", 32'(stall), 32'd0);
      chk("beq.fwd_d0", 32'(fwd_d0), 32'd2);
      chk("beq.fwd_d1", 32'(fwd_d1), 32'd0);
      chk("beq.e_wr", 32'(e_wr_addr), 32'd0);
      chk("beq.m_wr", 32'(m_wr_addr), 32'd3);
      tick();
      nop();
      chk("beq.w_wr", 32'(w_wr_addr), 32'd3);
      flush();

      // 3: lw $5 then addu $6,$5,$5
`ifdef HAZARD_STALL_CNT_EN
      cnt_snap = stall_cnt;
`endif
      set_d(5'd29, 2'd1, 5'd0, 2'd3, 5'd5, 2'd2);
      chk("lw5.stall", 32'(stall), 32'd0);
      tick();
      set_d(5'd5, 2'd1, 5'd5, 2'd1, 5'd6, 2'd1);
      chk("addu6.stall1", 32'(stall), 32'd1);
      tick();
      chk("addu6.stall2", 32'(stall), 32'd0);
      tick();
      nop();
      chk("addu6.fwd_e0", 32'(fwd_e0), 32'd3);
      chk("addu6.fwd_e1", 32'(fwd_e1), 32'd3);
      tick();
`ifdef HAZARD_STALL_CNT_EN
      chk("stall_cnt.delta", stall_cnt - cnt_snap, 32'd1);
`endif
      flush();

      // 4: jal then jr $31
      set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd31, 2'd0);
      tick();
      set_d(5'd31, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0);
      chk("jr.stall", 32'(stall), 32'd0);
      chk("jr.fwd_d0", 32'(fwd_d0), 32'd1);
      flush();

      // 5: lw $4 then sw $4 (rs $0 use 1, rt $4 use 2)
      set_d(5'd29, 2'd1, 5'd0, 2'd3, 5'd4, 2'd2);
      tick();
      set_d(5'd0, 2'd1, 5'd4, 2'd2, 5'd0, 2'd0);
      chk("sw.stall_d", 32'(stall), 32'd0);
      tick();
      nop();
      chk("sw.stall_e", 32'(stall), 32'd0);
      chk("sw.fwd_e1", 32'(fwd_e1), 32'd0);
      tick();
      chk("sw.fwd_m1", 32'(fwd_m1), 32'd3);
      flush();

      // 6: lw $0 then beq $0,$0
      set_d(5'd29, 2'd1, 5'd0, 2'd3, 5'd0, 2'd2);
      tick();
      set_d(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
      chk("r0.stall", 32'(stall), 32'd0);
      chk("r0.fwd", 32'({fwd_d0, fwd_d1}), 32'd0);
      flush();

      // lw $7 then beq $7: two-cycle stall, then forward from W
      set_d(5'd29, 2'd1, 5'd0, 2'd3, 5'd7, 2'd2);
      tick();
      set_d(5'd7, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
      chk("lwbr.stall1", 32'(stall), 32'd1);
      tick();
      chk("lwbr.stall2", 32'(stall), 32'd1);
      tick();
      chk("lwbr.stall3", 32'(stall), 32'd0);
      chk("lwbr.fwd_d0", 32'(fwd_d0), 32'd3);
      flush();

      // Newer writer in E shadows an older lw to the same register in M
      set_d(5'd29, 2'd1, 5'd0, 2'd3, 5'd8, 2'd2);
      tick();
      set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd0);
      tick();
      set_d(5'd8, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0);
      chk("shadow.stall", 32'(stall), 32'd0);
      chk("shadow.fwd_d0", 32'(fwd_d0), 32'd1);
      flush();

      // Reset asserted mid-stall clears every slot
      set_d(5'd29, 2'd1, 5'd0, 2'd3, 5'd9, 2'd2);
      tick();
      set_d(5'd9, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
      chk("midrst.stall", 32'(stall), 32'd1);
      reset = 1'b1;
      tick();
      chk_all_zero("midrst");
      reset = 1'b0;
      nop();
      tick();
      chk_all_zero("midrst_post");
`ifdef HAZARD_STALL_CNT_EN
      chk("stall_cnt.rst", stall_cnt, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
